// File: rtl/cpu_dbus_pkg.sv
// Shared types for the CPU data-bus responder: size codes, FSM state encoding, request record
// and the capture-time validity check.
package cpu_dbus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef logic [1:0] dbus_state_t;
  localparam dbus_state_t IDLE   = 2'd0;
  localparam dbus_state_t ACCESS = 2'd1;
  localparam dbus_state_t WAIT   = 2'd2;
  localparam dbus_state_t RESP   = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  byte_enable;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        err;
  } dbus_req_t;

  // Out of range, illegal size, misaligned, or write lane count not matching the size.
  function automatic logic req_invalid(input logic [31:0] addr, input logic write,
                                       input logic [3:0] be, input logic [1:0] size,
                                       input int unsigned addr_bits);
    logic [2:0] ones;
    logic       bad;
    ones = 3'(be[0]) + 3'(be[1]) + 3'(be[2]) + 3'(be[3]);
    bad  = (addr >> (addr_bits + 2)) != 32'd0;
    case (size)
      SIZE_BYTE: bad = bad | (write && ones != 3'd1);
      SIZE_HALF: bad = bad | addr[0] | (write && ones != 3'd2);
      SIZE_WORD: bad = bad | (addr[1:0] != 2'b00) | (write && ones != 3'd4);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Read data only changes on a read access, so it is held through any wait states.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        if (be_i[0]) mem_q[addr_i][7:0]   <= wdata_i[7:0];
        if (be_i[1]) mem_q[addr_i][15:8]  <= wdata_i[15:8];
        if (be_i[2]) mem_q[addr_i][23:16] <= wdata_i[23:16];
        if (be_i[3]) mem_q[addr_i][31:24] <= wdata_i[31:24];
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_dmem_responder.sv
// Data-bus responder: one active transaction plus one pending slot, configurable wait states,
// one-cycle ack with error qualifier, busy back-pressure and a sticky protocol-error flag.
module cpu_dmem_responder
  import cpu_dbus_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_request_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_write_i,
  input  logic [3:0]  cpu_byte_enable_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [1:0]  cpu_size_i,
  output logic        cpu_ack_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_error_o,
  output logic        cpu_busy_o,
  output logic        cpu_proto_err_o
);

  localparam logic [2:0] WaitInit = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  dbus_state_t state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  dbus_req_t   act_q, act_d, pend_q, pend_d, in_req;
  logic        pend_valid_q, pend_valid_d;
  logic        proto_err_q, proto_err_d;
  logic        ram_en;
  logic [31:0] ram_rdata;

  always_comb begin
    in_req.addr        = cpu_addr_i;
    in_req.write       = cpu_write_i;
    in_req.byte_enable = cpu_byte_enable_i;
    in_req.wdata       = cpu_wdata_i;
    in_req.size        = cpu_size_i;
    in_req.err         = req_invalid(cpu_addr_i, cpu_write_i, cpu_byte_enable_i, cpu_size_i,
                                     ADDR_BITS);
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    proto_err_d  = proto_err_q;

    // In RESP an incoming request with the slot empty bypasses straight into the active register.
    if (cpu_request_i && state_q != IDLE) begin
      if (pend_valid_q) begin
        proto_err_d = 1'b1;
      end else if (state_q != RESP) begin
        pend_d       = in_req;
        pend_valid_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (cpu_request_i) begin
          act_d   = in_req;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (WAIT_STATES > 0) begin
          state_d    = WAIT;
          wait_cnt_d = WaitInit;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 3'd0) state_d = RESP;
        else                    wait_cnt_d = wait_cnt_q - 3'd1;
      end
      RESP: begin
        if (pend_valid_q) begin
          act_d        = pend_q;
          pend_valid_d = 1'b0;
          state_d      = ACCESS;
        end else if (cpu_request_i) begin
          act_d   = in_req;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 3'd0;
      act_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign ram_en = (state_q == ACCESS) && !act_q.err;

  dmem_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (act_q.write),
    .be_i   (act_q.byte_enable),
    .addr_i (act_q.addr[ADDR_BITS+1:2]),
    .wdata_i(act_q.wdata),
    .rdata_o(ram_rdata)
  );

  assign cpu_ack_o       = (state_q == RESP);
  assign cpu_error_o     = cpu_ack_o && act_q.err;
  assign cpu_rdata_o     = (cpu_ack_o && !act_q.write && !act_q.err) ? ram_rdata : 32'd0;
  assign cpu_busy_o      = pend_valid_q;
  assign cpu_proto_err_o = proto_err_q;

  // Byte offset, upper address bits and size only matter for the capture-time check.
  logic unused_act;
  assign unused_act = ^{act_q.addr[1:0], act_q.addr[31:ADDR_BITS+2], act_q.size};

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Bench with two responders (0 and 3 wait states) checked against a word-array memory model.
module tb_cpu_dmem_responder;

  localparam int unsigned ByteSpan = 4 * 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_s  [2];
  logic [31:0] addr_s [2];
  logic        wr_s   [2];
  logic [3:0]  be_s   [2];
  logic [31:0] wd_s   [2];
  logic [1:0]  sz_s   [2];
  logic        ack_s  [2];
  logic [31:0] rd_s   [2];
  logic        err_s  [2];
  logic        busy_s [2];
  logic        perr_s [2];

  logic [31:0] mem_m [2][4096];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_dmem_responder #(.ADDR_BITS(12), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .cpu_request_i(req_s[0]), .cpu_addr_i(addr_s[0]),
    .cpu_write_i(wr_s[0]), .cpu_byte_enable_i(be_s[0]), .cpu_wdata_i(wd_s[0]),
    .cpu_size_i(sz_s[0]), .cpu_ack_o(ack_s[0]), .cpu_rdata_o(rd_s[0]), .cpu_error_o(err_s[0]),
    .cpu_busy_o(busy_s[0]), .cpu_proto_err_o(perr_s[0])
  );

  cpu_dmem_responder #(.ADDR_BITS(12), .WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .cpu_request_i(req_s[1]), .cpu_addr_i(addr_s[1]),
    .cpu_write_i(wr_s[1]), .cpu_byte_enable_i(be_s[1]), .cpu_wdata_i(wd_s[1]),
    .cpu_size_i(sz_s[1]), .cpu_ack_o(ack_s[1]), .cpu_rdata_o(rd_s[1]), .cpu_error_o(err_s[1]),
    .cpu_busy_o(busy_s[1]), .cpu_proto_err_o(perr_s[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 5;
  endfunction

  function automatic bit m_invalid(input logic [31:0] a, input logic w, input logic [3:0] be,
                                   input logic [1:0] sz);
    int span;
    span = 1 << sz;
    if (a >= ByteSpan) return 1'b1;
    if (sz == 2'd3) return 1'b1;
    if ((a % span) != 0) return 1'b1;
    if (w && $countones(be) != span) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_write(input int d, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
    for (int i = 0; i < 4; i++)
      if (be[i]) mem_m[d][int'(a >> 2)][8*i +: 8] = wd[8*i +: 8];
  endtask

  task automatic set_req(input int d, input logic [31:0] a, input logic w, input logic [3:0] be,
                         input logic [31:0] wd, input logic [1:0] sz);
    req_s[d] = 1'b1; addr_s[d] = a; wr_s[d] = w; be_s[d] = be; wd_s[d] = wd; sz_s[d] = sz;
  endtask

  // Issue one request from idle; report cycles to ack (-1 if none within budget).
  task automatic run_txn(input int d, input logic [31:0] a, input logic w, input logic [3:0] be,
                         input logic [31:0] wd, input logic [1:0] sz,
                         output int lat, output logic [31:0] rd, output logic er);
    lat = -1; rd = '0; er = 1'b0;
    @(negedge clk);
    set_req(d, a, w, be, wd, sz);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      req_s[d] = 1'b0;
      if (ack_s[d]) begin
        lat = i; rd = rd_s[d]; er = err_s[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (ack_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d]: got %b want 0", d, ack_s[d]); end
      n_tests++; if (rd_s[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rd_s[d]); end
      n_tests++; if (err_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", d, err_s[d]); end
      n_tests++; if (busy_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy_s[d]); end
      n_tests++; if (perr_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_perr[%0d]: got %b want 0", d, perr_s[d]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_rw();
    int lat; logic [31:0] rd; logic er;
    run_txn(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 2'b10, lat, rd, er);
    m_write(0, 32'h10, 4'hF, 32'hDEADBEEF);
    n_tests++; if (lat != 2 || er !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL word_write: lat=%0d err=%b rd=%h want lat=2 err=0 rd=0", lat, er, rd); end
    run_txn(0, 32'h10, 1'b0, 4'h0, 32'h0, 2'b10, lat, rd, er);
    n_tests++; if (lat != 2 || er !== 1'b0) begin n_fail++; $display("FAIL word_read_ack: lat=%0d err=%b want lat=2 err=0", lat, er); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_read_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_lane();
    int lat; logic [31:0] rd; logic er;
    run_txn(0, 32'h10, 1'b1, 4'hF, 32'h11223344, 2'b10, lat, rd, er);
    m_write(0, 32'h10, 4'hF, 32'h11223344);
    run_txn(0, 32'h13, 1'b1, 4'b1000, 32'hAB000000, 2'b00, lat, rd, er);
    m_write(0, 32'h13, 4'b1000, 32'hAB000000);
    n_tests++; if (lat != 2 || er !== 1'b0) begin n_fail++; $display("FAIL byte_write: lat=%0d err=%b want lat=2 err=0", lat, er); end
    run_txn(0, 32'h10, 1'b0, 4'h0, 32'h0, 2'b10, lat, rd, er);
    n_tests++; if (rd !== 32'hAB223344) begin n_fail++; $display("FAIL byte_merge: got %h want ab223344", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    run_txn(0, 32'h0, 1'b1, 4'hF, 32'h12345678, 2'b10, lat, rd, er);
    m_write(0, 32'h0, 4'hF, 32'h12345678);
    run_txn(0, 32'h2, 1'b0, 4'h0, 32'h0, 2'b10, lat, rd, er);
    n_tests++; if (lat != 2 || er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL misaligned_read: lat=%0d err=%b rd=%h want lat=2 err=1 rd=0", lat, er, rd); end
    run_txn(0, 32'h4000, 1'b0, 4'h0, 32'h0, 2'b10, lat, rd, er);
    n_tests++; if (lat != 2 || er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL range_read: lat=%0d err=%b rd=%h want lat=2 err=1 rd=0", lat, er, rd); end
    run_txn(0, 32'h4000, 1'b1, 4'hF, 32'hFFFFFFFF, 2'b10, lat, rd, er);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL range_write: err=%b want 1", er); end
    run_txn(0, 32'h10, 1'b1, 4'h0, 32'hFFFFFFFF, 2'b00, lat, rd, er);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL zero_be_write: err=%b want 1", er); end
    run_txn(0, 32'h0, 1'b0, 4'h0, 32'h0, 2'b10, lat, rd, er);
    n_tests++; if (rd !== 32'h12345678 || er !== 1'b0) begin n_fail++; $display("FAIL ram_untouched: got %h err=%b want 12345678 err=0", rd, er); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er;
    int ack_t[$]; logic [31:0] ack_d[$];
    run_txn(1, 32'h100, 1'b1, 4'hF, 32'hCAFE0001, 2'b10, lat, rd, er);
    m_write(1, 32'h100, 4'hF, 32'hCAFE0001);
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL ws3_latency: got %0d want 5", lat); end
    run_txn(1, 32'h104, 1'b1, 4'hF, 32'hCAFE0002, 2'b10, lat, rd, er);
    m_write(1, 32'h104, 4'hF, 32'hCAFE0002);
    @(negedge clk); set_req(1, 32'h100, 1'b0, 4'h0, 32'h0, 2'b10);
    @(negedge clk); set_req(1, 32'h104, 1'b0, 4'h0, 32'h0, 2'b10);
    for (int t = 2; t <= 14; t++) begin
      @(negedge clk);
      req_s[1] = 1'b0;
      if (ack_s[1]) begin ack_t.push_back(t); ack_d.push_back(rd_s[1]); end
      if (t <= 12) begin
        n_tests++; if (busy_s[1] !== logic'(t <= 5)) begin n_fail++; $display("FAIL b2b_busy@%0d: got %b want %b", t, busy_s[1], t <= 5); end
      end
    end
    n_tests++;
    if (ack_t.size() != 2 || ack_t[0] != 5 || ack_t[1] != 10) begin
      n_fail++; $display("FAIL b2b_ack_times: got %0d acks (%p) want 2 at 5,10", ack_t.size(), ack_t);
    end else begin
      n_tests++; if (ack_d[0] !== mem_m[1][64] || ack_d[1] !== mem_m[1][65]) begin n_fail++; $display("FAIL b2b_data: got %h %h want %h %h", ack_d[0], ack_d[1], mem_m[1][64], mem_m[1][65]); end
    end
    n_tests++; if (perr_s[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_proto: got %b want 0", perr_s[1]); end
  endtask

  task automatic test_proto_err();
    int ack_t[$]; logic [31:0] ack_d[$];
    @(negedge clk); set_req(1, 32'h100, 1'b0, 4'h0, 32'h0, 2'b10);
    @(negedge clk); set_req(1, 32'h104, 1'b0, 4'h0, 32'h0, 2'b10);
    for (int t = 2; t <= 14; t++) begin
      @(negedge clk);
      req_s[1] = 1'b0;
      if (ack_s[1]) begin ack_t.push_back(t); ack_d.push_back(rd_s[1]); end
      if (t == 3) set_req(1, 32'h100, 1'b1, 4'hF, 32'h0BADF00D, 2'b10);
    end
    n_tests++; if (ack_t.size() != 2) begin n_fail++; $display("FAIL proto_ack_count: got %0d want 2", ack_t.size()); end
    n_tests++; if (perr_s[1] !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %b want 1", perr_s[1]); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; int acks;
    @(negedge clk); set_req(1, 32'h100, 1'b0, 4'h0, 32'h0, 2'b10);
    @(negedge clk); set_req(1, 32'h104, 1'b1, 4'hF, 32'h55555555, 2'b10);
    @(negedge clk); req_s[1] = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_tests++; if (ack_s[1] !== 1'b0 || rd_s[1] !== 32'd0 || err_s[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: ack=%b rd=%h err=%b want 0", ack_s[1], rd_s[1], err_s[1]); end
    n_tests++; if (busy_s[1] !== 1'b0 || perr_s[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: busy=%b perr=%b want 0", busy_s[1], perr_s[1]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack_s[1]) acks++;
    end
    n_tests++; if (acks != 0) begin n_fail++; $display("FAIL midrst_stray_ack: got %0d want 0", acks); end
    run_txn(1, 32'h104, 1'b0, 4'h0, 32'h0, 2'b10, lat, rd, er);
    n_tests++; if (lat != 5 || rd !== mem_m[1][65]) begin n_fail++; $display("FAIL midrst_after: lat=%0d rd=%h want 5 %h", lat, rd, mem_m[1][65]); end
    run_txn(1, 32'h100, 1'b0, 4'h0, 32'h0, 2'b10, lat, rd, er);
    n_tests++; if (rd !== mem_m[1][64]) begin n_fail++; $display("FAIL discarded_write: got %h want %h", rd, mem_m[1][64]); end
  endtask

  task automatic test_random();
    int unsigned pool [2][8];
    int lat, off, d, widx; logic [31:0] rd, a, wd, exp_rd; logic er, w; logic [3:0] be;
    logic [1:0] sz; bit inv;
    for (int dd = 0; dd < 2; dd++)
      for (int k = 0; k < 8; k++) begin
        pool[dd][k] = $urandom_range(0, 4095);
        wd = $urandom;
        run_txn(dd, 32'(pool[dd][k] * 4), 1'b1, 4'hF, wd, 2'b10, lat, rd, er);
        m_write(dd, 32'(pool[dd][k] * 4), 4'hF, wd);
      end
    for (int n = 0; n < 60; n++) begin
      d    = int'($urandom_range(0, 1));
      widx = int'(pool[d][$urandom_range(0, 7)]);
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case (sz)
        2'd0:    begin off = int'($urandom_range(0, 3)); be = 4'(1 << off); end
        2'd1:    begin off = 2 * int'($urandom_range(0, 1)); be = 4'(3 << off); end
        default: begin off = 0; be = 4'hF; end
      endcase
      if ($urandom_range(0, 7) == 0) off = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) be = 4'($urandom_range(0, 15));
      a = 32'(widx * 4 + off);
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(14, 31));
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      inv    = m_invalid(a, w, be, sz);
      exp_rd = (!inv && !w) ? mem_m[d][int'(a >> 2)] : 32'd0;
      run_txn(d, a, w, be, wd, sz, lat, rd, er);
      n_tests++; if (lat != lat_of(d)) begin n_fail++; $display("FAIL rand_lat[%0d] dut%0d: got %0d want %0d", n, d, lat, lat_of(d)); end
      n_tests++; if (er !== logic'(inv)) begin n_fail++; $display("FAIL rand_err[%0d] dut%0d a=%h sz=%0d be=%b w=%b: got %b want %b", n, d, a, sz, be, w, er, inv); end
      n_tests++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_rdata[%0d] dut%0d a=%h: got %h want %h", n, d, a, rd, exp_rd); end
      if (!inv && w) m_write(d, a, be, wd);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 1'b0; addr_s[d] = '0; wr_s[d] = 1'b0; be_s[d] = '0; wd_s[d] = '0; sz_s[d] = '0;
    end
    test_reset();
    test_word_rw();
    test_byte_lane();
    test_errors();
    test_back_to_back();
    test_proto_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
